// File: rtl/imem_read_port_if.sv
// Fetch request/response, flush and program-load signals between the fetch stage and imem_read_port.
interface imem_read_port_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    modport master (
        output req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );
endinterface

// File: rtl/imem_read_port.sv
// Instruction memory responder: fixed-latency read pipeline feeding a response FIFO, plus a load port.
// Define IMEM_STATS_EN to add saturating accepted-request / error-request counters.
module imem_read_port #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int RSP_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    imem_read_port_if.slave   bus
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0]       stat_req_cnt,
    output logic [31:0]       stat_err_cnt
`endif
);
    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam int          PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int          PTR_W  = $clog2(RSP_DEPTH);
    localparam int          OCC_W  = $clog2(RSP_DEPTH + 1);
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [31:0] instr;
    } entry_t;

    logic [31:0]      mem [DEPTH_WORDS];
    logic             pipe_vld_q [PIPE_N];
    entry_t           pipe_q [PIPE_N];
    entry_t           fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] fifo_cnt_q;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             ready_q;
    logic             accept_s;
    logic             pop_s;
    logic             push_s;
    logic             addr_err_s;
    entry_t           acc_s;
    entry_t           tail_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] ld_idx_s;
    logic             unused_ld_bits_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RSP_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + 1'b1;
        end
    endfunction

    assign rd_idx_s         = bus.req_addr[IDX_W+1:2];
    assign ld_idx_s         = bus.ld_addr[IDX_W+1:2];
    assign unused_ld_bits_s = ^{bus.ld_addr[31:IDX_W+2], bus.ld_addr[1:0]};
    assign addr_err_s       = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:IDX_W+2] != '0);
    assign accept_s         = bus.req_valid && bus.req_ready;
    assign pop_s            = bus.rsp_valid && bus.rsp_ready;
    assign bus.req_ready    = ready_q && !bus.flush;
    assign bus.rsp_valid    = (fifo_cnt_q != '0);

    // Entry captured at the accept edge; an erroring request never indexes the array
    always_comb begin
        acc_s.err  = addr_err_s;
        acc_s.addr = bus.req_addr;
        if (addr_err_s) begin
            acc_s.instr = NOP;
        end else begin
            acc_s.instr = mem[rd_idx_s];
        end
    end

    // Program-load write; reads sample the old word on a same-edge collision
    always_ff @(posedge clk) begin
        if (bus.ld_en) begin
            mem[ld_idx_s] <= bus.ld_data;
        end
    end

    // Valid-tagged delay stages; the FIFO write forms the final latency stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_N; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_q[i]     <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < PIPE_N; i++) begin
                pipe_vld_q[i] <= 1'b0;
            end
        end else begin
            pipe_vld_q[0] <= accept_s;
            pipe_q[0]     <= acc_s;
            for (int i = 1; i < PIPE_N; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_q[i]     <= pipe_q[i-1];
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign push_s = accept_s;
            assign tail_s = acc_s;
        end else begin : g_piped
            assign push_s = pipe_vld_q[PIPE_N-1];
            assign tail_s = pipe_q[PIPE_N-1];
        end
    endgenerate

    // Response FIFO; occupancy limiting guarantees a free slot for every push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (bus.flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= tail_s;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            fifo_cnt_q <= fifo_cnt_q + OCC_W'(push_s) - OCC_W'(pop_s);
        end
    end

    // Outstanding-request count: pipeline plus buffer
    always_comb begin
        if (bus.flush) begin
            occ_d = '0;
        end else if (accept_s && !pop_s) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!accept_s && pop_s) begin
            occ_d = occ_q - OCC_W'(1);
        end else begin
            occ_d = occ_q;
        end
    end

    // Ready is registered from the next occupancy so rsp_ready never reaches req_ready combinationally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            ready_q <= (occ_d < OCC_W'(RSP_DEPTH));
        end
    end

    // Head entry drives the response bus; zeros while empty
    always_comb begin
        if (bus.rsp_valid) begin
            bus.rsp_instr = fifo_q[rd_ptr_q].instr;
            bus.rsp_addr  = fifo_q[rd_ptr_q].addr;
            bus.rsp_err   = fifo_q[rd_ptr_q].err;
        end else begin
            bus.rsp_instr = 32'h0000_0000;
            bus.rsp_addr  = 32'h0000_0000;
            bus.rsp_err   = 1'b0;
        end
    end

`ifdef IMEM_STATS_EN
    // Saturating statistics, untouched by flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_req_cnt <= 32'h0000_0000;
            stat_err_cnt <= 32'h0000_0000;
        end else begin
            if (accept_s && (stat_req_cnt != 32'hFFFF_FFFF)) begin
                stat_req_cnt <= stat_req_cnt + 32'd1;
            end
            if (accept_s && addr_err_s && (stat_err_cnt != 32'hFFFF_FFFF)) begin
                stat_err_cnt <= stat_err_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_imem_read_port.sv
// Directed self-checking bench for imem_read_port (DEPTH_WORDS=1024, LATENCY=2, RSP_DEPTH=4).
module tb_imem_read_port;
    localparam int          DEPTH_WORDS = 1024;
    localparam int          LATENCY     = 2;
    localparam int          RSP_DEPTH   = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [31:0] NEW_WORD    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] init_words [4];

    imem_read_port_if bus ();
`ifdef IMEM_STATS_EN
    logic [31:0] stat_req_cnt;
    logic [31:0] stat_err_cnt;
`endif

    imem_read_port #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY),
        .RSP_DEPTH   (RSP_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IMEM_STATS_EN
        ,
        .stat_req_cnt (stat_req_cnt),
        .stat_err_cnt (stat_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                             input logic err);
        check_eq({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check_eq({tag, "_instr"}, bus.rsp_instr, instr);
        check_eq({tag, "_addr"}, bus.rsp_addr, addr);
        check_eq({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        init_words[0] = 32'h1111_1111;
        init_words[1] = 32'h2222_2222;
        init_words[2] = 32'h3333_3333;
        init_words[3] = 32'h4444_4444;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.rsp_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = 32'h0;
        bus.ld_data   = 32'h0;

        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_instr", bus.rsp_instr, 32'd0);
        check_eq("rst_addr", bus.rsp_addr, 32'd0);
        check_eq("rst_err", 32'(bus.rsp_err), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
        cyc();

        for (int i = 0; i < 4; i++) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = 32'(4 * i);
            bus.ld_data = init_words[i];
            cyc();
        end
        bus.ld_en = 1'b0;

        // single request latency
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        cyc();
        bus.req_valid = 1'b0;
        #1;
        check_eq("lat_c1", 32'(bus.rsp_valid), 32'd0);
        cyc();
        check_rsp("lat_c2", init_words[0], 32'h0, 1'b0);
        cyc();
        check_eq("lat_c3", 32'(bus.rsp_valid), 32'd0);

        // back-to-back stream
        for (int t = 0; t < 7; t++) begin
            bus.req_valid = (t < 4);
            bus.req_addr  = 32'(4 * t);
            #1;
            if (t < 4) check_eq("str_ready", 32'(bus.req_ready), 32'd1);
            if (t >= 2 && t < 6) check_rsp("str_rsp", init_words[t-2], 32'(4 * (t - 2)), 1'b0);
            else check_eq("str_idle", 32'(bus.rsp_valid), 32'd0);
            cyc();
        end
        bus.req_valid = 1'b0;

        // backpressure fills the occupancy limit
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(4 * i);
            #1;
            check_eq("bp_ready", 32'(bus.req_ready), 32'd1);
            cyc();
        end
        bus.req_addr = 32'h0;
        #1;
        check_eq("bp_full4", 32'(bus.req_ready), 32'd0);
        check_rsp("bp_hold4", init_words[0], 32'h0, 1'b0);
        cyc();
        check_eq("bp_full5", 32'(bus.req_ready), 32'd0);
        check_rsp("bp_hold5", init_words[0], 32'h0, 1'b0);
        bus.rsp_ready = 1'b1;
        cyc();
        check_eq("bp_ready6", 32'(bus.req_ready), 32'd1);
        check_rsp("bp_rsp1", init_words[1], 32'h4, 1'b0);
        cyc();
        bus.req_valid = 1'b0;
        #1;
        check_eq("bp_ready7", 32'(bus.req_ready), 32'd1);
        check_rsp("bp_rsp2", init_words[2], 32'h8, 1'b0);
        cyc();
        check_rsp("bp_rsp3", init_words[3], 32'hC, 1'b0);
        cyc();
        check_rsp("bp_rsp5", init_words[0], 32'h0, 1'b0);
        cyc();
        check_eq("bp_empty", 32'(bus.rsp_valid), 32'd0);

        // misaligned and out-of-range
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h2;
        cyc();
        bus.req_addr = 32'h1000;
        cyc();
        bus.req_valid = 1'b0;
        #1;
        check_rsp("err_mis", NOP, 32'h2, 1'b1);
        cyc();
        check_rsp("err_oor", NOP, 32'h1000, 1'b1);
        cyc();
        check_eq("err_empty", 32'(bus.rsp_valid), 32'd0);

        // flush with three outstanding
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'(4 * i);
            cyc();
        end
        bus.req_addr = 32'hC;
        bus.flush    = 1'b1;
        #1;
        check_eq("fl_ready", 32'(bus.req_ready), 32'd0);
        check_eq("fl_pre_valid", 32'(bus.rsp_valid), 32'd1);
        cyc();
        bus.flush     = 1'b0;
        bus.req_addr  = 32'h4;
        bus.rsp_ready = 1'b1;
        #1;
        check_eq("fl_post_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("fl_post_ready", 32'(bus.req_ready), 32'd1);
        cyc();
        bus.req_valid = 1'b0;
        #1;
        check_eq("fl_c5", 32'(bus.rsp_valid), 32'd0);
        cyc();
        check_rsp("fl_rsp", init_words[1], 32'h4, 1'b0);
        cyc();
        check_eq("fl_only", 32'(bus.rsp_valid), 32'd0);

        // occupancy restarted from zero after flush
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'h0;
            #1;
            check_eq("fl_occ_ready", 32'(bus.req_ready), 32'd1);
            cyc();
        end
        bus.req_valid = 1'b0;
        #1;
        check_eq("fl_occ_full", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        repeat (6) cyc();
        check_eq("fl_drain", 32'(bus.rsp_valid), 32'd0);

        // load/accept collision returns the old word
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8;
        bus.ld_en     = 1'b1;
        bus.ld_addr   = 32'h8;
        bus.ld_data   = NEW_WORD;
        cyc();
        bus.req_valid = 1'b0;
        bus.ld_en     = 1'b0;
        cyc();
        check_rsp("rbw_old", init_words[2], 32'h8, 1'b0);
        cyc();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8;
        cyc();
        bus.req_valid = 1'b0;
        cyc();
        check_rsp("rbw_new", NEW_WORD, 32'h8, 1'b0);
        cyc();

        // reset mid-stream drops responses, keeps memory
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        cyc();
        bus.req_addr = 32'h4;
        cyc();
        bus.req_valid = 1'b0;
        cyc();
        check_eq("mr_pre", 32'(bus.rsp_valid), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("mr_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("mr_instr", bus.rsp_instr, 32'd0);
        cyc();
        reset = 1'b1;
        #1;
        check_eq("mr_ready", 32'(bus.req_ready), 32'd1);
        cyc();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        cyc();
        bus.req_addr = 32'h8;
        cyc();
        bus.req_valid = 1'b0;
        #1;
        check_rsp("mr_mem0", init_words[0], 32'h0, 1'b0);
        cyc();
        check_rsp("mr_mem8", NEW_WORD, 32'h8, 1'b0);
        cyc();
        check_eq("mr_empty", 32'(bus.rsp_valid), 32'd0);
`ifdef IMEM_STATS_EN
        check_eq("stat_req", stat_req_cnt, 32'd2);
        check_eq("stat_err", stat_err_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
